// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared opcodes, instruction field positions and FSM states for alu_ctrl_unit (ALU_CTRL_MUL_HI_EN adds the WB_HI state)
package alu_ctrl_pkg;
   localparam int DW = 16;
   localparam int AW = 3;
   localparam int NR = 8;
   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int RD_HI = 11;
   localparam int RD_LO = 9;
   localparam int RS_HI = 8;
   localparam int RS_LO = 6;
   localparam int RT_HI = 5;
   localparam int RT_LO = 3;
   localparam int IMM_HI = 8;
   localparam int IMM_LO = 0;
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_MUL = 4'h3;
   localparam logic [3:0] OP_DIV = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_NOR = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_ROR = 4'h9;
   localparam logic [3:0] OP_ROL = 4'hA;
   localparam logic [3:0] OP_LI  = 4'hF;
`ifdef ALU_CTRL_MUL_HI_EN
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_WB_HI} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
`endif
   function automatic logic is_illegal(input logic [3:0] op);
      return op inside {[4'hB:4'hE]};
   endfunction
endpackage

// File: rtl/alu_ctrl_regfile.sv
// alu_ctrl_regfile: 8x16 register file, two operand reads plus debug read, one synchronous write, R0 reads zero
module alu_ctrl_regfile
   import alu_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b,
   output logic [DW-1:0] dbg_data
);
   logic [DW-1:0] r [NR];
   assign rdata_a  = (raddr_a == '0) ? '0 : r[raddr_a];
   assign rdata_b  = (raddr_b == '0) ? '0 : r[raddr_b];
   assign dbg_data = (dbg_addr == '0) ? '0 : r[dbg_addr];
   // storage update; writes aimed at R0 are dropped
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < NR; i++) r[i] <= '0;
      else if (we && waddr != '0)
         r[waddr] <= wdata;
endmodule

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: sequences one instruction at a time through EXEC/WB to an external ALU; ALU_CTRL_MUL_HI_EN adds MUL high-half writeback
module alu_ctrl_unit
   import alu_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          instr_valid,
   input  logic [15:0]   instr,
   output logic          instr_ready,
   output logic [3:0]    alu_op,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_res16,
   input  logic [31:0]   alu_res32,
   output logic          wb_valid,
   output logic [AW-1:0] wb_addr,
   output logic [DW-1:0] wb_data,
   output logic          err,
   input  logic [AW-1:0] dbg_addr,
   output logic [DW-1:0] dbg_data
);
   state_t state, state_n;
   logic [3:0] op, op_q;
   logic [AW-1:0] rd_q;
   logic [8:0] imm_q;
   logic dz_q, skip_q;
   logic [DW-1:0] ra, rb, hi_data;
   logic accept, illegal, dz, hi_phase;
   assign op = instr[OP_HI:OP_LO];
   assign instr_ready = (state == S_IDLE) && !rst;
   assign accept = instr_valid && instr_ready;
   assign illegal = is_illegal(op);
   assign dz = (op == OP_DIV) && (rb == '0);
`ifdef ALU_CTRL_MUL_HI_EN
   logic [DW-1:0] hi_q;
   assign hi_phase = state == S_WB_HI;
   assign hi_data = hi_q;
   // hold the product high half across the low-half write
   always_ff @(posedge clk or posedge rst)
      if (rst)
         hi_q <= '0;
      else if (state == S_WB && op_q == OP_MUL)
         hi_q <= alu_res32[31:16];
`else
   logic unused_hi;
   assign unused_hi = ^alu_res32[31:16];
   assign hi_phase = 1'b0;
   assign hi_data = '0;
`endif
   assign wb_valid = (state == S_WB && !skip_q) || hi_phase;
   assign wb_addr = !wb_valid ? '0 : hi_phase ? rd_q + 3'd1 : rd_q;
   assign wb_data = !wb_valid ? '0 :
                    hi_phase ? hi_data :
                    dz_q ? 16'hFFFF :
                    op_q == OP_LI ? {7'b0, imm_q} :
                    op_q == OP_MUL ? alu_res32[15:0] : alu_res16;
   alu_ctrl_regfile u_rf (
      .clk      (clk),
      .rst      (rst),
      .we       (wb_valid),
      .waddr    (wb_addr),
      .wdata    (wb_data),
      .raddr_a  (instr[RS_HI:RS_LO]),
      .raddr_b  (instr[RT_HI:RT_LO]),
      .dbg_addr (dbg_addr),
      .rdata_a  (ra),
      .rdata_b  (rb),
      .dbg_data (dbg_data)
   );
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst)
         state <= S_IDLE;
      else
         state <= state_n;
   // next state: IDLE -> EXEC -> WB -> (WB_HI for MUL) -> IDLE
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = accept ? S_EXEC : S_IDLE;
         S_EXEC:  state_n = S_WB;
`ifdef ALU_CTRL_MUL_HI_EN
         S_WB:    state_n = (op_q == OP_MUL) ? S_WB_HI : S_IDLE;
`endif
         default: state_n = S_IDLE;
      endcase
   end
   // issue to the ALU on accept only; LI, illegal and divide-by-zero never reach the ALU
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         alu_op <= OP_NOP;
         alu_a  <= '0;
         alu_b  <= '0;
         err    <= 1'b0;
         op_q   <= OP_NOP;
         rd_q   <= '0;
         imm_q  <= '0;
         dz_q   <= 1'b0;
         skip_q <= 1'b0;
      end else begin
         alu_op <= (accept && !(illegal || dz || op == OP_LI)) ? op : OP_NOP;
         err    <= accept && (illegal || dz);
         if (accept) begin
            alu_a  <= ra;
            alu_b  <= rb;
            op_q   <= op;
            rd_q   <= instr[RD_HI:RD_LO];
            imm_q  <= instr[IMM_HI:IMM_LO];
            dz_q   <= dz;
            skip_q <= illegal || op == OP_NOP;
         end
      end
endmodule
